pipelined_barrel_shifter: RTL and testbench
===========================================

PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

Interface
REQ-001 Parameter W, default 8, data width; SHALL be a power of two, >= 2.
REQ-002 Parameter SW, default $clog2(W), shift-amount width and pipeline depth; SHALL NOT be overridden independently of W.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 up_valid  input  1  upstream operand valid.
REQ-006 up_ready  output  1  shifter can accept an operand this cycle.
REQ-007 up_data  input  W  operand.
REQ-008 up_shamt  input  SW  shift amount, 0..W-1.
REQ-009 up_mode  input  2  shift mode: 00 logical left, 01 logical right, 10 arithmetic right, 11 rotate right.
REQ-010 down_valid  output  1  result valid.
REQ-011 down_ready  input  1  downstream accepts the result this cycle.
REQ-012 down_data  output  W  result.

Function
REQ-013 A transfer SHALL occur on an interface in any cycle where its valid and ready are both high; in no other cycle.
REQ-014 The datapath SHALL have SW registered stages; stage k (k = 0..SW-1) SHALL shift by 2^k when shamt bit k is set, else pass through.
REQ-015 Each stage SHALL register data, remaining shamt bits, mode and a valid bit.
REQ-016 Logical left SHALL fill vacated LSBs with 0; logical right SHALL fill vacated MSBs with 0.
REQ-017 Arithmetic right SHALL fill vacated MSBs with the operand's original bit W-1.
REQ-018 Rotate right SHALL move bits shifted out of the LSB end into the MSB end, losing no bits.
REQ-019 Shamt 0 SHALL return up_data unchanged in every mode.
REQ-020 With down_ready held high, an operand accepted in cycle t SHALL appear on down_data with down_valid high in cycle t+SW.
REQ-021 Throughput SHALL be one operand per cycle while down_ready is high.
REQ-022 Stage k SHALL advance when it is empty or when stage k+1 advances; the last stage advances when down_valid and down_ready are both high, or when it is empty.
REQ-023 up_ready SHALL equal the advance condition of stage 0, combinationally, so the block accepts into a freed stage in the same cycle the results drain (no bubble on release of a stall).
REQ-024 While down_valid is high and down_ready low, down_data SHALL hold stable and the result SHALL NOT be lost or duplicated.
REQ-025 Under stall, the pipeline SHALL fill; once all SW stages are valid, up_ready SHALL be low.
REQ-026 Empty stages SHALL be collapsed: upstream operands SHALL advance into empty stages while a downstream stage is stalled.
REQ-027 Results SHALL leave in acceptance order.
REQ-028 Data, shamt and mode SHALL be ignored in cycles without an upstream transfer.

Reset
REQ-029 While rst is high at a clock edge, every stage valid bit SHALL clear; down_valid SHALL be 0 in the following cycle.
REQ-030 Reset mid-operation SHALL discard all in-flight operands; no discarded result SHALL ever appear on down_data with down_valid high.
REQ-031 up_ready SHALL be 1 in the first cycle after rst deasserts; data registers need no reset.

Verification (W = 8, SW = 3)
REQ-032 Data 10110001, shamt 3, modes 00/01/10/11 on consecutive cycles, down_ready=1 -> 10001000, 00010110, 11110110, 00110110 in cycles t+3..t+6.
REQ-033 Shamt 0 in each mode with data 10000001 -> 10000001 returned for all four; shamt 7 ASR of 10000000 -> 11111111.
REQ-034 Stream of 10 operands, down_ready=0 from the cycle the first result appears -> up_ready falls after 3 accepted operands; down_data stable; release down_ready -> all 10 results in order, no loss or duplicate.
REQ-035 down_ready toggled pseudo-randomly, up_valid random, 1000 operands -> every result matches a reference model in order.
REQ-036 rst asserted for 1 cycle with 3 operands in flight -> down_valid 0 next cycle, no stale result afterward, up_ready 1 after release.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one log2 stage per register, valid/ready at both ends.
// Modes: logical left, logical right, arithmetic right, rotate right.
module pipelined_barrel_shifter #(
  parameter int W  = 8,
  parameter int SW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [W-1:0]  up_data,
  input  logic [SW-1:0] up_shamt,
  input  logic [1:0]    up_mode,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [W-1:0]  down_data
);

  function automatic logic [W-1:0] shift_by(
    input logic [W-1:0] d,
    input logic [1:0]   m,
    input int           s
  );
    logic [W-1:0] o;
    o = d;
    case (m)
      2'b00:   o = d << s;
      2'b01:   o = d >> s;
      2'b10:   o = W'($signed(d) >>> s);
      default: o = (d >> s) | (d << (W - s));
    endcase
    return o;
  endfunction

  logic [W-1:0]  d_in [SW];
  logic [SW-1:0] s_in [SW];
  logic [1:0]    m_in [SW];
  logic [SW-1:0] v_in;
  logic [SW-1:0] v_st;
  logic [SW-1:0] adv;
  logic [W-1:0]  d_last;

  assign d_in[0] = up_data;
  assign s_in[0] = up_shamt;
  assign m_in[0] = up_mode;
  assign v_in[0] = up_valid;

  assign up_ready   = adv[0];
  assign down_valid = v_st[SW-1];
  assign down_data  = d_last;

  for (genvar k = 0; k < SW; k++) begin : g_stage
    localparam int S = 1 << k;
    logic [W-1:0] d_q;
    logic [W-1:0] nxt;
    logic         v_q;

    // A stage is blocked only when it and every later stage hold data
    // and the consumer is not taking the result.
    assign adv[k] = down_ready | ~(&v_st[SW-1:k]);
    assign nxt    = s_in[k][k] ? shift_by(d_in[k], m_in[k], S) : d_in[k];
    assign v_st[k] = v_q;

    // valid bit: cleared by reset, loaded from the previous stage on advance
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
      end else if (adv[k]) begin
        v_q <= v_in[k];
      end
    end

    // data register: no reset needed, qualified by the valid bit
    always_ff @(posedge clk) begin
      if (adv[k]) begin
        d_q <= nxt;
      end
    end

    if (k < SW - 1) begin : g_fwd
      logic [SW-1:0] s_q;
      logic [1:0]    m_q;

      // carry shift amount and mode forward to the next stage
      always_ff @(posedge clk) begin
        if (adv[k]) begin
          s_q <= s_in[k];
          m_q <= m_in[k];
        end
      end

      assign d_in[k+1] = d_q;
      assign s_in[k+1] = s_q;
      assign m_in[k+1] = m_q;
      assign v_in[k+1] = v_q;
    end else begin : g_out
      assign d_last = d_q;
    end
  end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (W=8).
// Reference model computes results from the operand with plain arithmetic.
module tb_pipelined_barrel_shifter;

  logic       clk = 1'b0;
  logic       rst;
  logic       up_valid;
  logic       up_ready;
  logic [7:0] up_data;
  logic [2:0] up_shamt;
  logic [1:0] up_mode;
  logic       down_valid;
  logic       down_ready;
  logic [7:0] down_data;

  pipelined_barrel_shifter #(.W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .up_shamt   (up_shamt),
    .up_mode    (up_mode),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc = 0;
  bit lat_mode = 0;
  bit held_ok = 0;
  logic [7:0] held;

  logic [7:0] exp_q [$];
  int         cyc_q [$];
  logic [7:0] got [$];
  logic [7:0] od [$];
  logic [2:0] os [$];
  logic [1:0] om [$];

  function automatic logic [7:0] model(int d, int s, int m);
    int r;
    r = 0;
    case (m)
      0: r = d << s;
      1: r = d >> s;
      2: begin
        r = (d >= 128) ? d - 256 : d;
        r = r >>> s;
      end
      default: r = (d >> s) | (d << (8 - s));
    endcase
    return 8'(r);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    int c;
    @(negedge clk);
    if (!rst) begin
      if (up_valid && up_ready) begin
        exp_q.push_back(model(int'(up_data), int'(up_shamt), int'(up_mode)));
        cyc_q.push_back(cyc);
        acc++;
      end
      if (held_ok) begin
        chk("hold_valid", down_valid, 1);
        chk("hold_data", down_data, held);
      end
      held_ok = 0;
      if (down_valid && down_ready) begin
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("result", down_data, exp_q.pop_front());
          c = cyc_q.pop_front();
          if (lat_mode) chk("latency", cyc - c, 3);
        end
        got.push_back(down_data);
      end else if (down_valid) begin
        held_ok = 1;
        held = down_data;
      end
    end else begin
      held_ok = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic feed();
    int g;
    g = 0;
    while (acc < od.size() && g < 500) begin
      up_valid = 1'b1;
      up_data  = od[acc];
      up_shamt = os[acc];
      up_mode  = om[acc];
      tick();
      g++;
    end
    up_valid = 1'b0;
    up_data  = 8'($urandom);
    chk("feed_done", acc, od.size());
  endtask

  task automatic drain();
    int g;
    g = 0;
    down_ready = 1'b1;
    while (exp_q.size() != 0 && g < 200) begin
      tick();
      g++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic set_ops_clear();
    od.delete();
    os.delete();
    om.delete();
    acc = 0;
  endtask

  task automatic add_op(logic [7:0] d, logic [2:0] s, logic [1:0] m);
    od.push_back(d);
    os.push_back(s);
    om.push_back(m);
  endtask

  initial begin
    int base;
    int g;
    rst        = 1'b1;
    up_valid   = 1'b0;
    up_data    = 8'h00;
    up_shamt   = 3'd0;
    up_mode    = 2'd0;
    down_ready = 1'b0;

    tick();
    chk("reset_down_valid", down_valid, 0);
    rst = 1'b0;
    #1;
    chk("reset_up_ready", up_ready, 1);

    // four modes, shamt 3, with latency checks
    lat_mode = 1;
    down_ready = 1'b1;
    base = got.size();
    set_ops_clear();
    for (int m = 0; m < 4; m++) add_op(8'hB1, 3'd3, 2'(m));
    feed();
    drain();
    chk("r032_count", got.size() - base, 4);
    if (got.size() - base == 4) begin
      chk("r032_lsl", got[base + 0], 8'h88);
      chk("r032_lsr", got[base + 1], 8'h16);
      chk("r032_asr", got[base + 2], 8'hF6);
      chk("r032_ror", got[base + 3], 8'h36);
    end

    // shamt 0 in every mode, full-range arithmetic shift
    base = got.size();
    set_ops_clear();
    for (int m = 0; m < 4; m++) add_op(8'h81, 3'd0, 2'(m));
    add_op(8'h80, 3'd7, 2'd2);
    feed();
    drain();
    chk("r033_count", got.size() - base, 5);
    if (got.size() - base == 5) begin
      for (int i = 0; i < 4; i++) chk("r033_zero", got[base + i], 8'h81);
      chk("r033_asr7", got[base + 4], 8'hFF);
    end
    lat_mode = 0;

    // stall with a 10-operand stream
    base = got.size();
    set_ops_clear();
    for (int i = 0; i < 10; i++) begin
      add_op(8'($urandom), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
    end
    down_ready = 1'b1;
    g = 0;
    while (!down_valid && g < 20) begin
      up_valid = 1'b1;
      up_data  = od[acc];
      up_shamt = os[acc];
      up_mode  = om[acc];
      tick();
      g++;
    end
    down_ready = 1'b0;
    up_data  = od[acc];
    up_shamt = os[acc];
    up_mode  = om[acc];
    #1;
    chk("r034_fill_count", acc, 3);
    chk("r034_full_ready", up_ready, 0);
    repeat (5) tick();
    chk("r034_stall_acc", acc, 3);
    chk("r034_stall_out", got.size() - base, 0);
    down_ready = 1'b1;
    feed();
    drain();
    chk("r034_count", got.size() - base, 10);

    // random traffic with random back-pressure
    set_ops_clear();
    g = 0;
    while (acc < 1000 && g < 20000) begin
      up_valid   = ($urandom % 4) != 0;
      up_data    = 8'($urandom);
      up_shamt   = 3'($urandom_range(0, 7));
      up_mode    = 2'($urandom_range(0, 3));
      down_ready = ($urandom % 3) != 0;
      tick();
      g++;
    end
    up_valid = 1'b0;
    chk("r035_accepted", acc, 1000);
    drain();

    // reset with three operands in flight
    set_ops_clear();
    down_ready = 1'b0;
    for (int i = 0; i < 3; i++) add_op(8'($urandom), 3'd1, 2'(i));
    feed();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    cyc_q.delete();
    chk("r036_down_valid", down_valid, 0);
    #1;
    chk("r036_up_ready", up_ready, 1);
    base = got.size();
    down_ready = 1'b1;
    repeat (10) tick();
    chk("r036_no_stale", got.size() - base, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
